memcpy_engine: RTL and testbench

MEMCPY_ENGINE -- requirements
Module: memcpy_engine

---
 rtl/memcpy_engine.sv | 127 ++++++++++++
 tb/tb_memcpy_engine.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memcpy_engine.sv
// memcpy_engine: word-granular memory-to-memory copy engine.
// It drives a dual-port data memory: port 1 for reads, port 2 for writes.
// Overlapping regions are handled by choosing the copy direction:
//   dst > src  -> copy descending, so source words are read before they are overwritten;
//   otherwise  -> copy ascending.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   start, src, dst     one-cycle copy request; byte addresses, which must be word aligned
//   len                 number of 32-bit words to copy
//   busy, done, err     status; done and err are one-cycle pulses
//   mem_we1/a1/wd1/rd1  memory port 1 (read only)
//   mem_we2/a2/wd2      memory port 2 (write)
module memcpy_engine #(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             mem_we1,
    output logic [31:0]      mem_a1,
    output logic [31:0]      mem_wd1,
    input  logic [31:0]      mem_rd1,
    output logic             mem_we2,
    output logic [31:0]      mem_a2,
    output logic [31:0]      mem_wd2
);

    typedef enum logic [1:0] {StIdle, StCopy, StDone} state_t;

    state_t           state_q, state_d;
    logic [31:0]      rd_ptr_q, rd_ptr_d;
    logic [31:0]      wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             desc_q, desc_d;
    logic             err_q, err_d;
    logic [31:0]      last_off;

    // Byte offset of the last word of the region.
    assign last_off = (32'(len) - 32'd1) << 2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            desc_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            desc_q   <= desc_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        desc_d   = desc_q;
        err_d    = 1'b0;
        mem_a1   = '0;
        mem_a2   = '0;
        mem_we2  = 1'b0;
        mem_wd2  = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (src[1:0] != 2'b00 || dst[1:0] != 2'b00) begin
                        err_d = 1'b1;
                    end else if (len == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StCopy;
                        cnt_d   = len;
                        if (dst > src) begin
                            desc_d   = 1'b1;
                            rd_ptr_d = src + last_off;
                            wr_ptr_d = dst + last_off;
                        end else begin
                            desc_d   = 1'b0;
                            rd_ptr_d = src;
                            wr_ptr_d = dst;
                        end
                    end
                end
            end
            StCopy: begin
                mem_a1   = rd_ptr_q;
                mem_a2   = wr_ptr_q;
                mem_we2  = 1'b1;
                // The read is combinational, so the word goes straight through.
                mem_wd2  = mem_rd1;
                rd_ptr_d = desc_q ? rd_ptr_q - 32'd4 : rd_ptr_q + 32'd4;
                wr_ptr_d = desc_q ? wr_ptr_q - 32'd4 : wr_ptr_q + 32'd4;
                cnt_d    = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign err     = err_q;
    assign mem_we1 = 1'b0;
    assign mem_wd1 = '0;

endmodule

// File: tb/tb_memcpy_engine.sv
// Directed testbench for memcpy_engine. It uses a 64-word memory model with
// combinational read and a write on the falling edge.
module tb_memcpy_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        err;
    logic        mem_we1;
    logic [31:0] mem_a1;
    logic [31:0] mem_wd1;
    logic [31:0] mem_rd1;
    logic        mem_we2;
    logic [31:0] mem_a2;
    logic [31:0] mem_wd2;

    memcpy_engine #(.LEN_W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .src     (src),
        .dst     (dst),
        .len     (len),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .mem_we1 (mem_we1),
        .mem_a1  (mem_a1),
        .mem_wd1 (mem_wd1),
        .mem_rd1 (mem_rd1),
        .mem_we2 (mem_we2),
        .mem_a2  (mem_a2),
        .mem_wd2 (mem_wd2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model; the bench preloads it through the same falling-edge process.
    logic [31:0] mem [64];
    logic        pl_we;
    logic [5:0]  pl_idx;
    logic [31:0] pl_data;
    int          write_count = 0;

    assign mem_rd1 = mem[mem_a1[7:2]];

    always @(negedge clk) begin
        if (pl_we) begin
            mem[pl_idx] <= pl_data;
        end else if (mem_we2) begin
            mem[mem_a2[7:2]] <= mem_wd2;
            write_count      <= write_count + 1;
        end
    end

    int checks   = 0;
    int failures = 0;
    int busy_n;
    int done_n;
    int err_n;
    int both_n   = 0;
    int wc0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] data);
        pl_we   = 1'b1;
        pl_idx  = 6'(idx);
        pl_data = data;
        @(negedge clk);
        #1;
        pl_we   = 1'b0;
    endtask

    task automatic clear_counts();
        busy_n = 0;
        done_n = 0;
        err_n  = 0;
        wc0    = write_count;
    endtask

    // Advance n cycles and sample the status outputs 1 time unit after each rising edge.
    task automatic tick_count(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (busy) busy_n++;
            if (done) done_n++;
            if (err) err_n++;
            if (err && done) both_n++;
        end
    endtask

    task automatic request(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        start = 1'b1;
        src   = s;
        dst   = d;
        len   = l;
    endtask

    localparam logic [31:0] VA = 32'hAAAA_0001;
    localparam logic [31:0] VB = 32'hBBBB_0002;
    localparam logic [31:0] VC = 32'hCCCC_0003;
    localparam logic [31:0] VD = 32'hDDDD_0004;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        src   = '0;
        dst   = '0;
        len   = '0;
        pl_we = 1'b0;
        pl_idx = '0;
        pl_data = '0;
        for (int i = 0; i < 64; i++) poke(i, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_we2", 32'(mem_we2), 32'd0);
        check("reset_a1", mem_a1, 32'h0);
        check("reset_a2", mem_a2, 32'h0);
        check("reset_wd2", mem_wd2, 32'h0);
        check("reset_we1_wd1", {31'd0, mem_we1} | mem_wd1, 32'h0);

        // Basic copy; dst > src, so it runs descending.
        poke(0, 32'h11); poke(1, 32'h22); poke(2, 32'h33); poke(3, 32'h44);
        request(32'h0, 32'h40, 16'd4);
        clear_counts();
        tick_count(1);
        check("basic_first_a1", mem_a1, 32'h0C);
        check("basic_first_a2", mem_a2, 32'h4C);
        check("basic_first_wd2", mem_wd2, 32'h44);
        check("basic_we2", 32'(mem_we2), 32'd1);
        // Later input changes must not disturb the copy in progress.
        start = 1'b0; src = 32'h20; dst = 32'h24; len = 16'd1;
        tick_count(7);
        check("basic_busy_cycles", 32'(busy_n), 32'd5);
        check("basic_done_pulses", 32'(done_n), 32'd1);
        check("basic_writes", 32'(write_count - wc0), 32'd4);
        check("basic_w16", mem[16], 32'h11);
        check("basic_w17", mem[17], 32'h22);
        check("basic_w18", mem[18], 32'h33);
        check("basic_w19", mem[19], 32'h44);
        check("basic_idle_a1", mem_a1, 32'h0);

        // Overlap forward.
        poke(0, VA); poke(1, VB); poke(2, VC); poke(3, VD); poke(4, 32'h0);
        request(32'h0, 32'h4, 16'd4);
        clear_counts();
        tick_count(1);
        start = 1'b0;
        check("fwd_first_a1", mem_a1, 32'h0C);
        check("fwd_first_a2", mem_a2, 32'h10);
        tick_count(6);
        check("fwd_w0", mem[0], VA);
        check("fwd_w1", mem[1], VA);
        check("fwd_w2", mem[2], VB);
        check("fwd_w3", mem[3], VC);
        check("fwd_w4", mem[4], VD);

        // Overlap backward; src > dst, so it runs ascending.
        poke(0, 32'h0); poke(1, VA); poke(2, VB); poke(3, VC); poke(4, VD);
        request(32'h4, 32'h0, 16'd4);
        clear_counts();
        tick_count(1);
        start = 1'b0;
        check("bwd_first_a1", mem_a1, 32'h4);
        check("bwd_first_a2", mem_a2, 32'h0);
        check("bwd_first_wd2", mem_wd2, VA);
        tick_count(6);
        check("bwd_w0", mem[0], VA);
        check("bwd_w1", mem[1], VB);
        check("bwd_w2", mem[2], VC);
        check("bwd_w3", mem[3], VD);

        // Zero length: DONE in the next cycle, with no write.
        request(32'h4, 32'h0, 16'd0);
        clear_counts();
        tick_count(1);
        start = 1'b0;
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd1);
        check("zero_we2", 32'(mem_we2), 32'd0);
        tick_count(2);
        check("zero_done_pulses", 32'(done_n), 32'd1);
        check("zero_writes", 32'(write_count - wc0), 32'd0);

        // Misaligned source.
        request(32'h2, 32'h40, 16'd2);
        clear_counts();
        tick_count(1);
        start = 1'b0;
        check("misal_err", 32'(err), 32'd1);
        check("misal_busy", 32'(busy), 32'd0);
        tick_count(3);
        check("misal_err_pulses", 32'(err_n), 32'd1);
        check("misal_busy_cycles", 32'(busy_n), 32'd0);
        check("misal_writes", 32'(write_count - wc0), 32'd0);
        check("misal_w16", mem[16], 32'h11);
        // Misaligned destination.
        request(32'h0, 32'h41, 16'd1);
        clear_counts();
        tick_count(1);
        start = 1'b0;
        check("misal_dst_err", 32'(err), 32'd1);
        tick_count(2);
        check("misal_dst_writes", 32'(write_count - wc0), 32'd0);

        // Reset mid-copy: the edge that would begin the third COPY cycle sees rst.
        for (int i = 0; i < 8; i++) poke(i, 32'h100 + 32'(i));
        for (int i = 32; i < 40; i++) poke(i, 32'h0);
        request(32'h0, 32'h80, 16'd8);
        clear_counts();
        tick_count(1);
        start = 1'b0;
        tick_count(1);
        rst = 1'b1;
        tick_count(1);
        rst = 1'b0;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        check("rstmid_we2", 32'(mem_we2), 32'd0);
        check("rstmid_a2", mem_a2, 32'h0);
        done_n = 0;
        busy_n = 0;
        tick_count(4);
        check("rstmid_no_done", 32'(done_n), 32'd0);
        check("rstmid_no_busy", 32'(busy_n), 32'd0);
        check("rstmid_writes", 32'(write_count - wc0), 32'd2);
        check("rstmid_w39", mem[39], 32'h107);
        check("rstmid_w38", mem[38], 32'h106);
        check("rstmid_w37", mem[37], 32'h0);

        // Start held high through COPY and DONE must be ignored.
        request(32'h0, 32'h80, 16'd2);
        clear_counts();
        tick_count(1);
        request(32'h0, 32'h90, 16'd3);
        tick_count(3);
        start = 1'b0;
        tick_count(4);
        check("sbusy_busy_cycles", 32'(busy_n), 32'd3);
        check("sbusy_done_pulses", 32'(done_n), 32'd1);
        check("sbusy_writes", 32'(write_count - wc0), 32'd2);
        check("sbusy_w32", mem[32], 32'h100);
        check("sbusy_w33", mem[33], 32'h101);
        check("sbusy_w36", mem[36], 32'h0);

        check("err_done_overlap", 32'(both_n), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
